mmio_bridge: RTL
================

# mmio_bridge

Memory-side bridge directly downstream of the CPU core's byte-wide memory bus. Decodes each bus cycle to either the 128 KB block RAM or the I/O window (`a[17:16]==2'b11`), buffers UART output bytes in a TX FIFO, and serves UART input plus a consistent 32-bit cycle counter. Returns read data exactly one cycle after the request. Sequences program stop: emit `'\0'`, drain the FIFO, then halt.

## Interface
- `TX_DEPTH`, 16: TX FIFO entries; power of two, ≥4.
- `FULL_SLACK`, 2: `io_buffer_full` asserts when occupancy ≥ `TX_DEPTH-FULL_SLACK`.
- `clk_in` in 1: system clock; the only clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: bus-cycle qualifier; when low, the bus request is ignored.
- `cpu_a` in 32: address; only [17:0] used.
- `cpu_wr` in 1: 1 = write.
- `cpu_dout` in 8: write data from the CPU.
- `cpu_din` out 8: read data, valid one cycle after the request.
- `io_buffer_full` out 1: TX near-full to the CPU.
- `ram_a` out 17: RAM address.
- `ram_we` out 1: RAM write strobe.
- `ram_din` out 8: RAM write data.
- `ram_dout` in 8: RAM read data, 1-cycle latency.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: UART TX handshake.
- `rx_data` in 8, `rx_valid` in 1, `rx_ready` out 1: UART RX handshake; `rx_ready` is a 1-cycle pop pulse.
- `program_stop` out 1: sticky; set when halted.
- `tx_overflow` out 1: sticky; set when a byte is dropped.

## Operation
- Request `req = rdy_in`. I/O select `io = cpu_a[17:16]==2'b11`.
- RAM path, combinational:
  - `ram_a = cpu_a[16:0]`.
  - `ram_din = cpu_dout`.
  - `ram_we = req & cpu_wr & ~io`.
- I/O writes (offset `cpu_a[2:0]`):
  - 0 with nonzero data: push to TX FIFO. Zero data is ignored.
  - 4: stop request.
  - Any other offset: ignored.
- I/O reads:
  - 0: if `rx_valid`, pulse `rx_ready` and return `rx_data`; else return 0x00.
  - 4: latch the live counter into `snap`; return `snap[7:0]` (i.e. live[7:0]).
  - 5, 6, 7: return `snap[15:8]`, `snap[23:16]`, `snap[31:24]`.
  - Other offsets: return 0x00.
- Read-return mux: a registered select (RAM / I/O) plus a registered I/O byte drive `cpu_din` on the next cycle. `cpu_din` holds its value when no read was issued.
- Cycle counter: 32-bit, increments every clock regardless of `rdy_in`, wraps 0xFFFFFFFF→0.
- TX FIFO:
  - Pointers are log2(`TX_DEPTH`) bits and wrap; count is log2+1 bits.
  - `tx_valid = ~empty`; `tx_data = head`.
  - Pop when `tx_valid & tx_ready`.
  - Simultaneous push and pop: count unchanged; legal even when full.
  - Push while full and no pop: byte dropped, `tx_overflow` set.
- Stop FSM:
  - RUN: stop request → push 0x00 (bypasses the zero filter), go to DRAIN.
  - DRAIN: FIFO empty and no pop in flight → HALT.
  - HALT: `program_stop=1`. All CPU writes are ignored (RAM and I/O); reads still served.
  - A stop request in DRAIN or HALT is ignored.

## Timing
- Reset values: `cpu_din`=0, `io_buffer_full`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=0, `program_stop`=0, `tx_overflow`=0, counter=0, `snap`=0, FSM=RUN, FIFO empty. The RAM-path outputs are combinational from the inputs.
- Reset mid-operation: FIFO contents and the pending stop are discarded immediately.
- Read latency: exactly 1 cycle for both RAM and I/O.
- Write side effects (FIFO push, stop request) take effect at the clock edge of the request cycle.
- `io_buffer_full` is registered from the post-update occupancy, so it is 1 cycle late; `FULL_SLACK` absorbs in-flight writes.
- `rx_ready` is asserted in the request cycle, combinationally from `req & ~cpu_wr & io & offset==0 & rx_valid`.
- `program_stop` rises 1 cycle after the FIFO becomes empty in DRAIN.

## Configuration
- `MMIO_RX_EN` defined: the RX read path operates as described.
- `MMIO_RX_EN` undefined:
  - `rx_ready` is tied to 0.
  - Offset-0 reads return 0x00.
  - `rx_data` and `rx_valid` are unused.

## Structure
- Shared package holds:
  - I/O offsets: `IO_UART=3'd0`, `IO_CLK=3'd4`.
  - The I/O region tag `2'b11`.
  - FSM state encoding: RUN, DRAIN, HALT.
- One sub-module: `byte_fifo`, parameterised on depth, with push/pop/count/full/empty. The bridge holds the decode, counter, snapshot, and FSM.

## Test plan
- Write 0xA5 to 0x00100, then read 0x00100 (`ram_dout`=0xA5 model) → `ram_we` pulses with `ram_a`=0x100; `cpu_din`=0xA5 on the cycle after the read.
- Write 'H', 0x00, 'i' to 0x30000 with `tx_ready`=1 → UART receives exactly 0x48, 0x69.
- Hold `tx_ready`=0; write 20 bytes with `TX_DEPTH`=16 →
  - `io_buffer_full` rises after the 14th push.
  - 16 bytes stored; `tx_overflow`=1.
- Counter preset near wrap: read 0x30004–0x30007 across the 0xFFFFFFFF→0 edge → the four bytes form the latched value, not a torn mix.
- 3 bytes queued, `tx_ready`=0; write to 0x30004 →
  - `program_stop` stays 0.
  - Release `tx_ready`: 3 bytes, then 0x00, then `program_stop`=1.
  - Subsequent RAM writes are suppressed.
- Assert `rst_in`=0 during DRAIN → all outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_bridge_pkg.sv
// Shared definitions for mmio_bridge: I/O decode constants, FSM encoding and
// the read-return select.
package mmio_bridge_pkg;

  localparam logic [2:0] IO_UART   = 3'd0;
  localparam logic [2:0] IO_CLK    = 3'd4;
  localparam logic [2:0] IO_CLK_B1 = 3'd5;
  localparam logic [2:0] IO_CLK_B2 = 3'd6;
  localparam logic [2:0] IO_CLK_B3 = 3'd7;
  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } stop_state_e;

  typedef enum logic {
    SEL_RAM = 1'b0,
    SEL_IO  = 1'b1
  } rd_sel_e;

endpackage

// File: rtl/mmio_bridge_byte_fifo.sv
// byte_fifo: power-of-two depth byte FIFO with wrapping pointers and a
// one-bit-wider occupancy count. A push while full is accepted only with a pop.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes CPU byte-bus cycles to RAM or the I/O window, queues
// UART TX bytes, snapshots the cycle counter, sequences stop/drain/halt.
// Optional MMIO_RX_EN enables the UART RX read path at I/O offset 0.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int TX_DEPTH   = 16,
  parameter int FULL_SLACK = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(TX_DEPTH - FULL_SLACK);

  stop_state_e   state_q;
  rd_sel_e       rd_sel_q;
  logic [31:0]   cnt_q, snap_q;
  logic [7:0]    io_byte_q, io_byte_d, hold_q, uart_rd_byte, fifo_din;
  logic          rd_pend_q, full_q, ovf_q, stop_q;
  logic          io, halted, wr_ok, rd, uart_wr, stop_req;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, push_ok;
  logic [CW-1:0] fifo_count, count_post;
  logic [2:0]    off;
  logic          unused_addr;

  assign io     = (cpu_a[17:16] == IO_REGION);
  assign off    = cpu_a[2:0];
  assign halted = (state_q == ST_HALT);
  assign wr_ok  = rdy_in & cpu_wr & ~halted;
  assign rd     = rdy_in & ~cpu_wr;
  assign unused_addr = &{1'b0, cpu_a[31:18]};

  assign ram_a   = cpu_a[16:0];
  assign ram_din = cpu_dout;
  assign ram_we  = wr_ok & ~io;

  // The stop marker is the only zero byte that may enter the FIFO.
  assign uart_wr   = wr_ok & io & (off == IO_UART) & (cpu_dout != 8'h00);
  assign stop_req  = wr_ok & io & (off == IO_CLK) & (state_q == ST_RUN);
  assign fifo_push = uart_wr | stop_req;
  assign fifo_din  = stop_req ? 8'h00 : cpu_dout;
  assign fifo_pop  = tx_valid & tx_ready;
  assign tx_valid  = ~fifo_empty;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .head_o  (tx_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign push_ok    = fifo_push & (~fifo_full | fifo_pop);
  assign count_post = fifo_count + CW'(push_ok) - CW'(fifo_pop);

`ifdef MMIO_RX_EN
  assign rx_ready     = rd & io & (off == IO_UART) & rx_valid;
  assign uart_rd_byte = rx_valid ? rx_data : 8'h00;
`else
  logic unused_rx;
  assign unused_rx    = &{1'b0, rx_data, rx_valid};
  assign rx_ready     = 1'b0;
  assign uart_rd_byte = 8'h00;
`endif

  always_comb begin
    io_byte_d = 8'h00;
    case (off)
      IO_UART:   io_byte_d = uart_rd_byte;
      IO_CLK:    io_byte_d = cnt_q[7:0];
      IO_CLK_B1: io_byte_d = snap_q[15:8];
      IO_CLK_B2: io_byte_d = snap_q[23:16];
      IO_CLK_B3: io_byte_d = snap_q[31:24];
      default:   io_byte_d = 8'h00;
    endcase
  end

  // RAM data only exists in the cycle after a read, so idle cycles replay hold_q.
  assign cpu_din = rd_pend_q ? ((rd_sel_q == SEL_IO) ? io_byte_q : ram_dout) : hold_q;

  assign io_buffer_full = full_q;
  assign tx_overflow    = ovf_q;
  assign program_stop   = stop_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q     <= '0;
      snap_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_sel_q  <= SEL_RAM;
      io_byte_q <= 8'h00;
      hold_q    <= 8'h00;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_q + 32'd1;
      rd_pend_q <= rd;
      hold_q    <= cpu_din;
      if (rd) begin
        rd_sel_q  <= io ? SEL_IO : SEL_RAM;
        io_byte_q <= io_byte_d;
      end
      if (rd & io & (off == IO_CLK)) snap_q <= cnt_q;
      full_q <= (count_post >= FULL_LVL);
      if (fifo_push & fifo_full & ~fifo_pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_RUN;
      stop_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN:   if (stop_req) state_q <= ST_DRAIN;
        ST_DRAIN: if (fifo_empty & ~fifo_push) begin
          state_q <= ST_HALT;
          stop_q  <= 1'b1;
        end
        ST_HALT:  stop_q <= 1'b1;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

endmodule
